// File: rtl/pattern_wave_pkg.sv
// Shared types and defaults for the pattern wave generator.
package pattern_wave_pkg;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StRun  = 1'b1
   } state_e;

   localparam int unsigned PatWDefault     = 16;
   localparam int unsigned ChannelsDefault = 2;
   localparam int unsigned DivWDefault     = 8;

   // $clog2 that never collapses to a zero-width vector.
   function automatic int unsigned clog2_min1(input int unsigned value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

endpackage

// File: rtl/wave_tick_divider.sv
// Step divider: emits one tick every divisor+1 enabled cycles; load restarts it.
module wave_tick_divider #(
   parameter int unsigned DIV_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             enable,
   input  logic [DIV_W-1:0] divisor,
   output logic             tick
);

   logic [DIV_W-1:0] count_q;
   logic [DIV_W-1:0] div_q;

   assign tick = enable && (count_q == div_q);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         div_q   <= '0;
      end else if (load) begin
         count_q <= '0;
         div_q   <= divisor;
      end else if (enable) begin
         count_q <= tick ? '0 : count_q + DIV_W'(1);
      end
   end

endmodule

// File: rtl/pattern_wave_generator.sv
// Multi-channel serial pattern player with shared step divider and step clock output.
module pattern_wave_generator
   import pattern_wave_pkg::*;
#(
   parameter int unsigned PAT_W    = PatWDefault,
   parameter int unsigned CHANNELS = ChannelsDefault,
   parameter int unsigned DIV_W    = DivWDefault
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              io_cfgValid,
   output logic                              io_cfgReady,
   input  logic [clog2_min1(CHANNELS)-1:0]   io_cfgChannel,
   input  logic [PAT_W-1:0]                  io_cfgPattern,
   input  logic [$clog2(PAT_W):0]            io_cfgLength,
   input  logic                              io_cfgOneShot,
   input  logic [DIV_W-1:0]                  io_divisor,
   input  logic                              io_start,
   input  logic                              io_stop,
   output logic [CHANNELS-1:0]               io_wave,
   output logic                              io_clockWave,
   output logic                              io_busy,
   output logic                              io_done
);

   localparam int unsigned ChW  = clog2_min1(CHANNELS);
   localparam int unsigned LenW = $clog2(PAT_W) + 1;
   localparam int unsigned IdxW = clog2_min1(PAT_W);

   state_e              state_q, state_d;
   logic [PAT_W-1:0]    pattern_q [CHANNELS];
   logic [LenW-1:0]     length_q  [CHANNELS];
   logic [IdxW-1:0]     index_q   [CHANNELS];
   logic [CHANNELS-1:0] oneshot_q;
   logic [CHANNELS-1:0] finished_q;
   logic [CHANNELS-1:0] is_last;
   logic                clk_wave_q;
   logic                done_q;
   logic                tick;
   logic                run;
   logic                start_run;
   logic                complete;
   logic                all_done;
   logic                cfg_accept;
   logic [LenW-1:0]     cfg_len;

   assign run          = (state_q == StRun);
   assign cfg_accept   = !run && io_cfgValid;
   assign cfg_len      = (io_cfgLength == '0 || 32'(io_cfgLength) > PAT_W) ?
                         LenW'(PAT_W) : io_cfgLength;
   assign io_cfgReady  = !run;
   assign io_busy      = run;
   assign io_done      = done_q;
   assign io_clockWave = clk_wave_q;

   wave_tick_divider #(
      .DIV_W (DIV_W)
   ) u_divider (
      .clock   (clock),
      .reset   (reset),
      .load    (start_run),
      .enable  (run),
      .divisor (io_divisor),
      .tick    (tick)
   );

   always_comb begin
      state_d   = state_q;
      start_run = 1'b0;
      complete  = 1'b0;
      all_done  = 1'b1;
      is_last   = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         is_last[c] = (LenW'(index_q[c]) == length_q[c] - LenW'(1));
         // A channel counts as done if it already finished or finishes on this tick.
         all_done = all_done &&
                    (finished_q[c] || (tick && oneshot_q[c] && is_last[c]));
      end
      unique case (state_q)
         StIdle: begin
            if (io_start && !io_stop) begin
               state_d   = StRun;
               start_run = 1'b1;
            end
         end
         StRun: begin
            if (io_stop) begin
               state_d = StIdle;
            end else if (all_done) begin
               state_d  = StIdle;
               complete = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      io_wave = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         io_wave[c] = run && !finished_q[c] && pattern_q[c][index_q[c]];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         clk_wave_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_wave_q <= (run && state_d == StRun) ? (clk_wave_q ^ tick) : 1'b0;
         done_q     <= complete;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         oneshot_q  <= '0;
         finished_q <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            pattern_q[c] <= '0;
            length_q[c]  <= LenW'(PAT_W);
            index_q[c]   <= '0;
         end
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (cfg_accept && io_cfgChannel == ChW'(c)) begin
               pattern_q[c] <= io_cfgPattern;
               length_q[c]  <= cfg_len;
               oneshot_q[c] <= io_cfgOneShot;
            end
            if (start_run) begin
               index_q[c]    <= '0;
               finished_q[c] <= 1'b0;
            end else if (run && tick && !finished_q[c]) begin
               if (is_last[c]) begin
                  if (oneshot_q[c]) begin
                     finished_q[c] <= 1'b1;
                  end else begin
                     index_q[c] <= '0;
                  end
               end else begin
                  index_q[c] <= index_q[c] + IdxW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_pattern_wave_generator.sv
// Directed self-checking bench for pattern_wave_generator (PAT_W=16, CHANNELS=2, DIV_W=8).
module tb_pattern_wave_generator;

   logic        clock;
   logic        reset;
   logic        io_cfgValid;
   logic        io_cfgReady;
   logic [0:0]  io_cfgChannel;
   logic [15:0] io_cfgPattern;
   logic [4:0]  io_cfgLength;
   logic        io_cfgOneShot;
   logic [7:0]  io_divisor;
   logic        io_start;
   logic        io_stop;
   logic [1:0]  io_wave;
   logic        io_clockWave;
   logic        io_busy;
   logic        io_done;

   int tests = 0;
   int fails = 0;

   pattern_wave_generator dut (
      .clock         (clock),
      .reset         (reset),
      .io_cfgValid   (io_cfgValid),
      .io_cfgReady   (io_cfgReady),
      .io_cfgChannel (io_cfgChannel),
      .io_cfgPattern (io_cfgPattern),
      .io_cfgLength  (io_cfgLength),
      .io_cfgOneShot (io_cfgOneShot),
      .io_divisor    (io_divisor),
      .io_start      (io_start),
      .io_stop       (io_stop),
      .io_wave       (io_wave),
      .io_clockWave  (io_clockWave),
      .io_busy       (io_busy),
      .io_done       (io_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench did not finish");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic cfg_write(input logic ch, input logic [15:0] pat, input logic [4:0] len,
                            input logic os, input logic start);
      io_cfgValid   = 1'b1;
      io_cfgChannel = ch;
      io_cfgPattern = pat;
      io_cfgLength  = len;
      io_cfgOneShot = os;
      io_start      = start;
      step();
      io_cfgValid = 1'b0;
      io_start    = 1'b0;
   endtask

   task automatic stop_run();
      io_stop = 1'b1;
      step();
      io_stop = 1'b0;
   endtask

   logic [6:0]  exp36 = 7'b1001010;
   logic [11:0] exp37 = 12'b1110_0011_1000;
   logic [1:0]  exp39 [13] = '{2'd3, 2'd1, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1,
                               2'd1, 2'd2, 2'd1, 2'd1, 2'd0, 2'd3};

   initial begin
      reset         = 1'b0;
      io_cfgValid   = 1'b0;
      io_cfgChannel = '0;
      io_cfgPattern = '0;
      io_cfgLength  = '0;
      io_cfgOneShot = 1'b0;
      io_divisor    = '0;
      io_start      = 1'b0;
      io_stop       = 1'b0;
      #1;
      check("reset_wave", 32'(io_wave), 32'd0);
      check("reset_clockwave", 32'(io_clockWave), 32'd0);
      check("reset_busy", 32'(io_busy), 32'd0);
      check("reset_done", 32'(io_done), 32'd0);
      check("reset_cfgready", 32'(io_cfgReady), 32'd1);
      step();
      reset = 1'b1;
      step();

      // Repeat 0x0A over 5 bits, divisor 0, config and start together.
      io_divisor = 8'd0;
      cfg_write(1'b0, 16'h000A, 5'd5, 1'b0, 1'b1);
      check("run_busy", 32'(io_busy), 32'd1);
      check("run_cfgready", 32'(io_cfgReady), 32'd0);
      for (int k = 0; k < 7; k++) begin
         check($sformatf("div0_wave_k%0d", k), 32'(io_wave[0]), 32'(exp36[k]));
         check($sformatf("div0_clk_k%0d", k), 32'(io_clockWave), 32'(k % 2));
         step();
      end
      stop_run();
      check("stop1_busy", 32'(io_busy), 32'd0);

      // Same pattern, divisor 2: bits held 3 cycles, step clock period 6.
      io_divisor = 8'd2;
      io_start   = 1'b1;
      step();
      io_start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         check($sformatf("div2_wave_k%0d", k), 32'(io_wave[0]), 32'(exp37[k]));
         check($sformatf("div2_clk_k%0d", k), 32'(io_clockWave), 32'(exp37[k]));
         step();
      end
      stop_run();

      // One-shot 0b101, length 3; ch1 one-shot single zero bit.
      io_divisor = 8'd0;
      cfg_write(1'b1, 16'h0000, 5'd1, 1'b1, 1'b0);
      cfg_write(1'b0, 16'h0005, 5'd3, 1'b1, 1'b1);
      check("os_w_t1", 32'(io_wave), 32'd1);
      check("os_busy_t1", 32'(io_busy), 32'd1);
      step();
      check("os_w_t2", 32'(io_wave), 32'd0);
      step();
      check("os_w_t3", 32'(io_wave), 32'd1);
      check("os_done_t3", 32'(io_done), 32'd0);
      step();
      check("os_done_t4", 32'(io_done), 32'd1);
      check("os_busy_t4", 32'(io_busy), 32'd0);
      check("os_w_t4", 32'(io_wave), 32'd0);
      check("os_clk_t4", 32'(io_clockWave), 32'd0);
      step();
      check("os_done_t5", 32'(io_done), 32'd0);

      // Independent wrap of lengths 3 and 4, realigning after 12 steps.
      cfg_write(1'b0, 16'h0003, 5'd3, 1'b0, 1'b0);
      cfg_write(1'b1, 16'h0001, 5'd4, 1'b0, 1'b1);
      for (int k = 0; k < 13; k++) begin
         check($sformatf("wrap_k%0d", k), 32'(io_wave), 32'(exp39[k]));
         if (k == 6 || k == 7) begin
            check($sformatf("wrap_cfgready_k%0d", k), 32'(io_cfgReady), 32'd0);
         end
         if (k == 5) begin
            io_cfgValid   = 1'b1;
            io_cfgChannel = 1'b0;
            io_cfgPattern = 16'h0000;
            io_cfgLength  = 5'd1;
            io_start      = 1'b1;
         end else if (k == 8) begin
            io_cfgValid = 1'b0;
            io_start    = 1'b0;
         end
         step();
      end
      stop_run();
      check("stop2_wave", 32'(io_wave), 32'd0);

      // Length 0 plays all 16 bits; ch1 one-shot single bit.
      cfg_write(1'b1, 16'h0000, 5'd1, 1'b1, 1'b0);
      cfg_write(1'b0, 16'h8001, 5'd0, 1'b1, 1'b1);
      for (int k = 0; k < 16; k++) begin
         check($sformatf("len0_k%0d", k), 32'(io_wave[0]), 32'((k == 0 || k == 15) ? 1 : 0));
         step();
      end
      check("len0_done", 32'(io_done), 32'd1);
      check("len0_busy", 32'(io_busy), 32'd0);
      step();

      // Stop mid-run, with start also high: stop wins.
      cfg_write(1'b0, 16'hFFFF, 5'd0, 1'b0, 1'b1);
      step();
      check("mid_wave", 32'(io_wave[0]), 32'd1);
      check("mid_clk", 32'(io_clockWave), 32'd1);
      io_start = 1'b1;
      stop_run();
      io_start = 1'b0;
      check("midstop_wave", 32'(io_wave), 32'd0);
      check("midstop_clk", 32'(io_clockWave), 32'd0);
      check("midstop_busy", 32'(io_busy), 32'd0);
      check("midstop_done", 32'(io_done), 32'd0);
      io_start = 1'b1;
      io_stop  = 1'b1;
      step();
      io_start = 1'b0;
      io_stop  = 1'b0;
      check("idle_stop_prio", 32'(io_busy), 32'd0);

      // Reset in the middle of a run clears outputs at once, no done pulse.
      io_start = 1'b1;
      step();
      io_start = 1'b0;
      step();
      check("prerst_wave", 32'(io_wave[0]), 32'd1);
      check("prerst_clk", 32'(io_clockWave), 32'd1);
      reset = 1'b0;
      #1;
      check("rst_wave", 32'(io_wave), 32'd0);
      check("rst_clk", 32'(io_clockWave), 32'd0);
      check("rst_busy", 32'(io_busy), 32'd0);
      check("rst_done", 32'(io_done), 32'd0);
      step();
      reset = 1'b1;
      step();
      check("postrst_done", 32'(io_done), 32'd0);
      check("postrst_ready", 32'(io_cfgReady), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pattern_wave_generator.md
PATTERN_WAVE_GENERATOR -- requirements
Module: pattern_wave_generator

Interface
REQ-001 SHALL have parameter PAT_W, default 16: maximum pattern length in bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 2: number of independent wave outputs.
REQ-003 SHALL have parameter DIV_W, default 8: width of the step divisor.
REQ-004 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port io_cfgValid, input, 1: config write request.
REQ-007 SHALL have port io_cfgReady, output, 1: config accepted this cycle when high together with io_cfgValid.
REQ-008 SHALL have port io_cfgChannel, input, clog2(CHANNELS): target channel of the config write.
REQ-009 SHALL have port io_cfgPattern, input, PAT_W: pattern bits, bit 0 emitted first.
REQ-010 SHALL have port io_cfgLength, input, clog2(PAT_W)+1: pattern length in bits.
REQ-011 SHALL have port io_cfgOneShot, input, 1: 1 = play once, 0 = repeat.
REQ-012 SHALL have port io_divisor, input, DIV_W: each bit is held io_divisor+1 cycles.
REQ-013 SHALL have port io_start, input, 1: start request.
REQ-014 SHALL have port io_stop, input, 1: abort request.
REQ-015 SHALL have port io_wave, output, CHANNELS: per-channel serial pattern output.
REQ-016 SHALL have port io_clockWave, output, 1: toggles at every step boundary.
REQ-017 SHALL have port io_busy, output, 1: high in RUN.
REQ-018 SHALL have port io_done, output, 1: one-cycle completion pulse.

Function
REQ-019 SHALL implement FSM states IDLE and RUN.
REQ-020 SHALL drive io_cfgReady = 1 in IDLE and 0 in RUN; config writes in RUN are ignored.
REQ-021 SHALL store an io_cfgLength of 0 or greater than PAT_W as PAT_W.
REQ-022 SHALL, on io_start in IDLE at cycle T, enter RUN at T+1 with every channel index at 0, the divider count at 0, io_divisor latched, and io_clockWave = 0.
REQ-023 SHALL, when io_cfgValid and io_start occur in the same IDLE cycle, run with the newly written config.
REQ-024 SHALL give priority to io_stop over io_start when both are high in the same cycle.
REQ-025 SHALL drive io_wave[c] = pattern[c][index[c]] combinationally from registered state in RUN, and 0 in IDLE.
REQ-026 SHALL generate a step tick every latched divisor+1 cycles in RUN, and toggle io_clockWave on each tick.
REQ-027 SHALL, on each tick, advance index[c], wrapping to 0 after length[c]-1 in repeat mode; channels wrap independently.
REQ-028 SHALL, in one-shot mode, mark channel c finished after its last bit's hold period, after which io_wave[c] = 0.
REQ-029 SHALL return to IDLE when all channels are finished, pulsing io_done high for exactly the first IDLE cycle; a mix of repeat and one-shot channels never completes.
REQ-030 SHALL, on io_stop in RUN, enter IDLE next cycle with io_wave = 0, io_clockWave = 0 and io_done = 0.
REQ-031 SHALL ignore io_start while in RUN.

Reset
REQ-032 SHALL, on reset assertion, immediately force: state IDLE; all patterns 0; lengths PAT_W; mode repeat; indices, divider and finished flags 0; io_wave = 0; io_clockWave = 0; io_busy = 0; io_done = 0.
REQ-033 SHALL abort any run in progress on reset, with no io_done pulse.

Structure
REQ-034 SHALL place the state enum and parameter defaults in shared package pattern_wave_pkg.
REQ-035 SHALL implement the step divider as sub-module wave_tick_divider (load, enable, tick output).

Verification
REQ-036 SHALL cover: ch0 pattern 0x0A, length 5, repeat, divisor 0 -> io_wave[0] = 0,1,0,1,0,0,1,... from T+1; io_clockWave toggles every cycle.
REQ-037 SHALL cover: same config with divisor 2 -> each bit held 3 cycles; io_clockWave period 6 cycles.
REQ-038 SHALL cover: pattern 0b101, length 3, one-shot, divisor 0, start at T -> wave 1,0,1 at T+1..T+3; io_done high and io_busy low at T+4 only.
REQ-039 SHALL cover: ch0 length 3, ch1 length 4, both repeat -> independent wrap, realigning every 12 steps; cfgValid in RUN leaves cfgReady 0 and output unchanged.
REQ-040 SHALL cover: length 0 -> full PAT_W playback; stop mid-run -> all outputs 0 next cycle; reset mid-run -> all outputs 0 immediately, no io_done.
